// File: rtl/data_cache_memory_interface_pkg.sv
`timescale 1ns/1ps
// Shared defaults, address-field widths and FSM encodings for the data cache.
package data_cache_memory_interface_pkg;

    localparam int DEF_NUM_LINES      = 16;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_MEM_LATENCY    = 4;
    localparam int DEF_MEM_WORDS      = 1024;

    localparam int WORD_W        = 32;
    localparam int ADDR_W        = 32;
    localparam int BYTE_OFFSET_W = 2;

    // Address field widths derived from a line geometry.
    function automatic int offset_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int num_lines, input int words_per_line);
        return ADDR_W - BYTE_OFFSET_W - offset_width(words_per_line) - index_width(num_lines);
    endfunction

    // Field widths for the default geometry: offset addr[3:2], index addr[7:4], tag addr[31:8].
    localparam int DEF_OFFSET_W = offset_width(DEF_WORDS_PER_LINE);
    localparam int DEF_INDEX_W  = index_width(DEF_NUM_LINES);
    localparam int DEF_TAG_W    = tag_width(DEF_NUM_LINES, DEF_WORDS_PER_LINE);

    // Refill FSM; code 2'b11 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WRITEBACK = 2'b01,
        ST_ALLOCATE  = 2'b10
    } state_t;

endpackage

// File: rtl/data_cache_memory_interface_mux4.sv
`timescale 1ns/1ps
// Four-way word selector used to pick the addressed word out of a cache line.
module mux4
    import data_cache_memory_interface_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] out
);

    // Pure combinational select; every select value is decoded.
    always_comb begin
        unique case (select)
            2'd0:    out = d0;
            2'd1:    out = d1;
            2'd2:    out = d2;
            default: out = d3;
        endcase
    end

endmodule

// File: rtl/data_cache_memory_interface.sv
`timescale 1ns/1ps
// Direct-mapped, write-back / write-allocate data cache in front of a
// fixed-latency backing memory. Misses stall the requester while the FSM
// optionally writes back the dirty victim and then refills the line.
module data_cache_memory_interface
    import data_cache_memory_interface_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int MEM_LATENCY    = DEF_MEM_LATENCY,
    parameter int MEM_WORDS      = DEF_MEM_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RE,
    input  logic                WE,
    input  logic [WORD_W-1:0]   WD,
    input  logic [ADDR_W-1:0]   addr,
    output logic [WORD_W-1:0]   RD,
    output logic                stall,
    output logic                cache_hit,
    output logic                cache_miss,
    output logic                valid_dirty,
    output logic [1:0]          idle_plus,
    output logic                stall_latch
);

    localparam int OFFSET_W   = offset_width(WORDS_PER_LINE);
    localparam int INDEX_W    = index_width(NUM_LINES);
    localparam int TAG_W      = tag_width(NUM_LINES, WORDS_PER_LINE);
    localparam int MEM_ADDR_W = $clog2(MEM_WORDS);
    localparam int CNT_W      = $clog2(MEM_LATENCY + 1);

    // Address decode; the byte-within-word bits carry no meaning here.
    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                unused_byte_bits;

    assign offset           = addr[BYTE_OFFSET_W +: OFFSET_W];
    assign index            = addr[BYTE_OFFSET_W + OFFSET_W +: INDEX_W];
    assign tag              = addr[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^addr[BYTE_OFFSET_W-1:0];

    // Line storage and backing memory. Valid/dirty and backing memory power
    // up as zero; data and tags are don't-care until a line becomes valid.
    logic [WORD_W-1:0]    line_data [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]     line_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] line_valid = '0;
    logic [NUM_LINES-1:0] line_dirty = '0;
    logic [WORD_W-1:0]    backing_mem [MEM_WORDS] = '{default: '0};

    // FSM and transfer bookkeeping.
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [INDEX_W-1:0]  miss_index_q;
    logic [TAG_W-1:0]    miss_tag_q;

    logic                req, match, read_hit, write_hit;
    logic                capture, wb_done, fill_done, last_cnt;
    logic [WORD_W-1:0]   hit_word;
    logic [MEM_ADDR_W-1:0] victim_base, fill_base;

    // Word select within the addressed line.
    generate
        if (WORDS_PER_LINE == 4) begin : g_mux4
            mux4 #(.WIDTH(WORD_W)) u_word_mux (
                .select (offset),
                .d0     (line_data[index][0]),
                .d1     (line_data[index][1]),
                .d2     (line_data[index][2]),
                .d3     (line_data[index][3]),
                .out    (hit_word)
            );
        end else begin : g_index
            assign hit_word = line_data[index][offset];
        end
    endgenerate

    // Backing-memory word addresses of the victim line and of the line being filled.
    assign victim_base = MEM_ADDR_W'({line_tag[miss_index_q], miss_index_q, {OFFSET_W{1'b0}}});
    assign fill_base   = MEM_ADDR_W'({miss_tag_q, miss_index_q, {OFFSET_W{1'b0}}});

    // Hit/miss/stall flags and read data for the current request.
    always_comb begin
        req         = RE | WE;
        match       = line_valid[index] & (line_tag[index] == tag);
        cache_hit   = req & match & (state_q == ST_IDLE);
        cache_miss  = req & ~match;
        stall       = req & ~cache_hit;
        valid_dirty = line_valid[index] & line_dirty[index];
        idle_plus   = state_q;
        read_hit    = cache_hit & RE & ~WE;
        write_hit   = cache_hit & WE;
        RD          = read_hit ? hit_word : '0;
    end

    // Next-state logic: a miss in IDLE captures the line, then writeback (if dirty) and allocate each run MEM_LATENCY cycles.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        wb_done   = 1'b0;
        fill_done = 1'b0;
        last_cnt  = (cnt_q == CNT_W'(MEM_LATENCY - 1));
        case (state_q)
            ST_IDLE: begin
                if (cache_miss) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = valid_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (last_cnt) begin
                    wb_done = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ALLOCATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ALLOCATE: begin
                if (last_cnt) begin
                    fill_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, transfer counter and registered stall; the only reset-cleared state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_latch <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_latch <= stall;
        end
    end

    // Line arrays and backing memory: write hits, miss capture, writeback and refill.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are never cleared by reset; reset only suppresses updates so an abandoned transfer leaves lines untouched.
        if (!reset) begin
            if (write_hit) begin
                line_data[index][offset] <= WD;
                line_dirty[index]        <= 1'b1;
            end
            if (capture) begin
                miss_index_q <= index;
                miss_tag_q   <= tag;
            end
            if (wb_done) begin
                for (int w = 0; w < WORDS_PER_LINE; w++) begin
                    backing_mem[victim_base + MEM_ADDR_W'(w)] <= line_data[miss_index_q][w];
                end
            end
            if (fill_done) begin
                for (int w = 0; w < WORDS_PER_LINE; w++) begin
                    line_data[miss_index_q][w] <= backing_mem[fill_base + MEM_ADDR_W'(w)];
                end
                line_tag[miss_index_q]   <= miss_tag_q;
                line_valid[miss_index_q] <= 1'b1;
                line_dirty[miss_index_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_memory_interface.sv
`timescale 1ns/1ps
// Self-checking bench: directed scenarios followed by random accesses, all
// checked against a line-level behavioural model of the cache and memory.
module tb_data_cache_memory_interface;
    import data_cache_memory_interface_pkg::*;

    localparam int L   = DEF_MEM_LATENCY;
    localparam int NL  = DEF_NUM_LINES;
    localparam int WPL = DEF_WORDS_PER_LINE;
    localparam int MW  = DEF_MEM_WORDS;

    logic        clk, reset, RE, WE;
    logic [31:0] WD, addr, RD;
    logic        stall, cache_hit, cache_miss, valid_dirty, stall_latch;
    logic [1:0]  idle_plus;

    data_cache_memory_interface dut (
        .clk         (clk),
        .reset       (reset),
        .RE          (RE),
        .WE          (WE),
        .WD          (WD),
        .addr        (addr),
        .RD          (RD),
        .stall       (stall),
        .cache_hit   (cache_hit),
        .cache_miss  (cache_miss),
        .valid_dirty (valid_dirty),
        .idle_plus   (idle_plus),
        .stall_latch (stall_latch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: line contents plus a flat word-addressed memory.
    bit          m_valid [NL];
    bit          m_dirty [NL];
    int          m_tag   [NL];
    logic [31:0] m_data  [NL][WPL];
    logic [31:0] m_mem   [MW];

    function automatic int mem_word(input int tg, input int idx, input int w);
        return ((tg * NL + idx) * WPL + w) % MW;
    endfunction

    // Expected FSM code n cycles after a request is presented.
    function automatic logic [1:0] exp_state(input int n, input bit hit, input bit wb);
        if (hit || n == 0) return 2'b00;
        if (wb) begin
            if (n <= L)     return 2'b01;
            if (n <= 2 * L) return 2'b10;
            return 2'b00;
        end
        if (n <= L) return 2'b10;
        return 2'b00;
    endfunction

    // stall_latch must always echo the previous cycle's stall (0 after a reset cycle);
    // with no request, stall must be low whatever the FSM is doing.
    bit prev_stall;
    bit prev_reset;
    always @(negedge clk) begin
        check("stall_latch", {31'b0, stall_latch}, {31'b0, prev_reset ? 1'b0 : prev_stall});
        if (!RE && !WE) check("stall_noreq", {31'b0, stall}, 32'd0);
        prev_stall = stall;
        prev_reset = reset;
    end

    // Present one request (called just after a rising edge) and follow it to its hit cycle.
    task automatic do_access(input logic re, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input int drop_at);
        int          idx, tg, off, exp_stall, n;
        bit          hit, wb, vd_exp, done;
        logic [31:0] exp_rd;
        idx       = int'(a[7:4]);
        tg        = int'(a[31:8]);
        off       = int'(a[3:2]);
        hit       = m_valid[idx] && (m_tag[idx] == tg);
        vd_exp    = m_valid[idx] && m_dirty[idx];
        wb        = !hit && vd_exp;
        exp_stall = hit ? 0 : (wb ? 1 + 2 * L : 1 + L);
        RE = re; WE = we; addr = a; WD = wd;
        if (!hit) begin
            if (wb)
                for (int w = 0; w < WPL; w++) m_mem[mem_word(m_tag[idx], idx, w)] = m_data[idx][w];
            for (int w = 0; w < WPL; w++) m_data[idx][w] = m_mem[mem_word(tg, idx, w)];
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        exp_rd = m_data[idx][off];
        n      = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (n == 0) begin
                check("valid_dirty", {31'b0, valid_dirty}, {31'b0, vd_exp});
                check("cache_miss", {31'b0, cache_miss}, {31'b0, !hit});
            end
            check("idle_plus", {30'b0, idle_plus}, {30'b0, exp_state(n, hit, wb)});
            if (n == exp_stall) begin
                check("cache_hit", {31'b0, cache_hit}, 32'd1);
                check("stall_at_hit", {31'b0, stall}, 32'd0);
                check("RD", RD, (re && !we) ? exp_rd : 32'd0);
                done = 1'b1;
            end else if (n == drop_at) begin
                check("stall_dropped", {31'b0, stall}, 32'd0);
            end else begin
                check("stall_refill", {31'b0, stall}, 32'd1);
                check("RD_refill", RD, 32'd0);
            end
            @(posedge clk);
            #1;
            if (!done) begin
                if (n + 1 == drop_at) begin
                    RE = 1'b0; WE = 1'b0;
                end else if (n == drop_at) begin
                    RE = re; WE = we;
                end
            end
            n++;
        end
        if (we) begin
            m_data[idx][off] = wd;
            m_dirty[idx]     = 1'b1;
        end
        RE = 1'b0; WE = 1'b0;
    endtask

    // Idle cycles with no request: no stall, no hit, valid_dirty tracks the addressed line.
    task automatic idle_cycles(input int k, input logic [31:0] a);
        int idx;
        idx = int'(a[7:4]);
        RE = 1'b0; WE = 1'b0; addr = a;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("idle_stall", {31'b0, stall}, 32'd0);
            check("idle_hit", {31'b0, cache_hit}, 32'd0);
            check("idle_valid_dirty", {31'b0, valid_dirty}, {31'b0, m_valid[idx] && m_dirty[idx]});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int tg, idx, off, kind, drop;
        n_checks = 0; n_errors = 0;
        prev_stall = 1'b0; prev_reset = 1'b1;
        reset = 1'b1; RE = 1'b0; WE = 1'b0; WD = '0; addr = '0;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0;
            for (int w = 0; w < WPL; w++) m_data[i][w] = '0;
        end
        for (int i = 0; i < MW; i++) m_mem[i] = '0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_idle_plus", {30'b0, idle_plus}, 32'd0);
        check("reset_stall_latch", {31'b0, stall_latch}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;

        // Cold read miss, write hit, read back.
        do_access(1'b1, 1'b0, 32'h100, 32'h0, -1);
        do_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, -1);
        idle_cycles(1, 32'h100);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, -1);

        // Conflicting line forces a writeback, then the original line returns from memory.
        do_access(1'b1, 1'b0, 32'h200, 32'h0, -1);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, -1);

        // Reset in the second ALLOCATE cycle abandons the refill.
        RE = 1'b1; WE = 1'b0; addr = 32'h300;
        @(negedge clk);
        check("rst_scn_miss", {31'b0, cache_miss}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_scn_alloc1", {30'b0, idle_plus}, 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_scn_alloc2", {30'b0, idle_plus}, 32'd2);
        @(posedge clk); #1;
        reset = 1'b0; RE = 1'b0;
        @(negedge clk);
        check("rst_scn_idle_plus", {30'b0, idle_plus}, 32'd0);
        check("rst_scn_stall_latch", {31'b0, stall_latch}, 32'd0);
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h300, 32'h0, -1);

        // Request dropped mid-refill: the refill still completes.
        do_access(1'b1, 1'b0, 32'h400, 32'h0, 2);

        // Random traffic over a small tag range to force conflicts and writebacks.
        for (int it = 0; it < 250; it++) begin
            tg   = $urandom_range(0, 7);
            idx  = $urandom_range(0, NL - 1);
            off  = $urandom_range(0, WPL - 1);
            a    = 32'(tg * 256 + idx * 16 + off * 4 + $urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L) : -1;
            case (kind)
                0, 1:    do_access(1'b1, 1'b0, a, 32'h0, drop);
                2:       do_access(1'b0, 1'b1, a, $urandom, drop);
                default: do_access(1'b1, 1'b1, a, $urandom, drop);
            endcase
            idle_cycles($urandom_range(1, 2), a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
